// File: rtl/pio_bank_avmm.sv
// Avalon-MM PIO bank: NUM_OUT output words and NUM_IN debounced input words with
// edge capture (write-1-to-clear), per-bit IRQ masking and one registered level interrupt.
module pio_bank_avmm #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       NUM_OUT      = 4,
  parameter int unsigned       NUM_IN       = 2,
  parameter logic [DATA_W-1:0] OUT_RESET    = '0,
  parameter int unsigned       DEBOUNCE_CYC = 50000,
  parameter int unsigned       EDGE_MODE    = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [4:0]                avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [DATA_W-1:0]         avs_writedata,
  input  logic [DATA_W/8-1:0]       avs_byteenable,
  output logic [DATA_W-1:0]         avs_readdata,
  output logic [NUM_OUT*DATA_W-1:0] out_export,
  input  logic [NUM_IN*DATA_W-1:0]  in_export,
  output logic                      irq
);

  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned CNT_W   = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned CNT_MAX = (DEBOUNCE_CYC == 0) ? 0 : DEBOUNCE_CYC - 1;

  logic [DATA_W-1:0] r_out    [NUM_OUT];
  logic [DATA_W-1:0] r_mask   [NUM_IN];
  logic [DATA_W-1:0] r_edge   [NUM_IN];
  logic [DATA_W-1:0] r_in     [NUM_IN];
  logic [DATA_W-1:0] r_sync1  [NUM_IN];
  logic [DATA_W-1:0] r_sync2  [NUM_IN];
  logic [DATA_W-1:0] r_sync_d [NUM_IN];
  logic [CNT_W-1:0]  r_cnt    [NUM_IN];
  logic [NUM_IN-1:0] r_primed;
  logic [DATA_W-1:0] r_readdata;
  logic              r_irq;

  logic [DATA_W-1:0] w_raw      [NUM_IN];
  logic [DATA_W-1:0] w_det      [NUM_IN];
  logic [DATA_W-1:0] w_set      [NUM_IN];
  logic [DATA_W-1:0] w_clr      [NUM_IN];
  logic [DATA_W-1:0] w_edge_nxt [NUM_IN];
  logic [NUM_IN-1:0] w_load;
  logic [DATA_W-1:0] w_irqstat;
  logic [DATA_W-1:0] w_rdata;

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_OUT; g++) begin : g_out
      assign out_export[g*DATA_W +: DATA_W] = r_out[g];
    end
    for (g = 0; g < NUM_IN; g++) begin : g_in
      assign w_raw[g] = in_export[g*DATA_W +: DATA_W];
    end
  endgenerate

  // Debounce acceptance and edge capture; a same-cycle set beats the W1C clear.
  always_comb begin
    w_load = '0;
    for (int n = 0; n < NUM_IN; n++) begin
      w_det[n]      = '0;
      w_set[n]      = '0;
      w_clr[n]      = '0;
      w_edge_nxt[n] = r_edge[n];
      w_load[n] = (DEBOUNCE_CYC == 0) ? 1'b1 :
                  ((r_sync2[n] == r_sync_d[n]) && (r_cnt[n] == CNT_W'(CNT_MAX)));
      if (EDGE_MODE == 0)      w_det[n] = ~r_in[n] & r_sync2[n];
      else if (EDGE_MODE == 1) w_det[n] = r_in[n] & ~r_sync2[n];
      else                     w_det[n] = r_in[n] ^ r_sync2[n];
      if (w_load[n] && r_primed[n]) w_set[n] = w_det[n];
      if (avs_write && (avs_address == 5'(12 + n))) w_clr[n] = avs_writedata;
      w_edge_nxt[n] = (r_edge[n] & ~w_clr[n]) | w_set[n];
    end
  end

  always_comb begin
    w_irqstat = '0;
    for (int n = 0; n < NUM_IN; n++) begin
      w_irqstat[n] = |(r_edge[n] & r_mask[n]);
    end
  end

  // Read mux; absent channels and holes decode to zero.
  always_comb begin
    w_rdata = '0;
    for (int n = 0; n < NUM_OUT; n++) begin
      if (avs_address == 5'(n)) w_rdata = r_out[n];
    end
    for (int n = 0; n < NUM_IN; n++) begin
      if (avs_address == 5'(8 + n))  w_rdata = r_in[n];
      if (avs_address == 5'(12 + n)) w_rdata = r_edge[n];
      if (avs_address == 5'(16 + n)) w_rdata = r_mask[n];
    end
    if (avs_address == 5'h14) w_rdata = w_irqstat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_OUT; n++) r_out[n] <= OUT_RESET;
      for (int n = 0; n < NUM_IN; n++) begin
        r_mask[n]   <= '0;
        r_edge[n]   <= '0;
        r_in[n]     <= '0;
        r_sync1[n]  <= '0;
        r_sync2[n]  <= '0;
        r_sync_d[n] <= '0;
        r_cnt[n]    <= '0;
      end
      r_primed   <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_OUT; n++) begin
        if (avs_write && (avs_address == 5'(n)))
          r_out[n] <= f_merge(r_out[n], avs_writedata, avs_byteenable);
      end
      for (int n = 0; n < NUM_IN; n++) begin
        if (avs_write && (avs_address == 5'(16 + n)))
          r_mask[n] <= f_merge(r_mask[n], avs_writedata, avs_byteenable);
        r_edge[n]   <= w_edge_nxt[n];
        r_sync1[n]  <= w_raw[n];
        r_sync2[n]  <= r_sync1[n];
        r_sync_d[n] <= r_sync2[n];
        if (r_sync2[n] != r_sync_d[n])
          r_cnt[n] <= '0;
        else if (r_cnt[n] != CNT_W'(CNT_MAX))
          r_cnt[n] <= r_cnt[n] + CNT_W'(1);
        if (w_load[n]) begin
          r_in[n]     <= r_sync2[n];
          r_primed[n] <= 1'b1;
        end
      end
      if (avs_read) r_readdata <= w_rdata;
      r_irq <= |w_irqstat;
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_pio_bank_avmm.sv
// Directed bench for pio_bank_avmm: register map, byte lanes, debounce, priming,
// edge capture, W1C and interrupt timing.
module tb_pio_bank_avmm;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned NUM_IN  = 2;
  localparam logic [31:0] OUT_RST = 32'h1234_5678;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [4:0]                avs_address;
  logic                      avs_read;
  logic                      avs_write;
  logic [DATA_W-1:0]         avs_writedata;
  logic [DATA_W/8-1:0]       avs_byteenable;
  logic [DATA_W-1:0]         avs_readdata;
  logic [NUM_OUT*DATA_W-1:0] out_export;
  logic [NUM_IN*DATA_W-1:0]  in_export;
  logic                      irq;

  int total = 0;
  int bad   = 0;

  pio_bank_avmm #(
    .DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .OUT_RESET(OUT_RST),
    .DEBOUNCE_CYC(8), .EDGE_MODE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .out_export(out_export), .in_export(in_export), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic do_reset(input logic [63:0] in_val);
    reset_n = 1'b0; in_export = in_val;
    avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0; avs_byteenable = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d, exp;
    do_reset(64'h0);
    total++; if (avs_readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata got=%h exp=0", avs_readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    total++; if (out_export !== {4{OUT_RST}}) begin bad++; $display("FAIL rst_out_export got=%h exp=%h", out_export, {4{OUT_RST}}); end
    for (int a = 0; a <= 'h14; a++) begin
      exp = (a < 4) ? OUT_RST : 32'h0;
      bus_read(5'(a), d);
      total++; if (d !== exp) begin bad++; $display("FAIL rst_read addr=%0h got=%h exp=%h", a, d, exp); end
    end
  endtask

  task automatic test_out_byteenable();
    logic [31:0] d;
    bus_write(5'h01, 32'hA5A5_A5A5, 4'b0010);
    total++; if (out_export[63:32] !== 32'h1234_A578) begin bad++; $display("FAIL be_export1 got=%h exp=1234a578", out_export[63:32]); end
    bus_read(5'h01, d);
    total++; if (d !== 32'h1234_A578) begin bad++; $display("FAIL be_read1 got=%h exp=1234a578", d); end
    bus_write(5'h03, 32'hDEAD_BEEF, 4'b1111);
    total++; if (out_export !== {32'hDEAD_BEEF, OUT_RST, 32'h1234_A578, OUT_RST}) begin bad++; $display("FAIL be_export_all got=%h", out_export); end
    bus_write(5'h05, 32'hFFFF_FFFF, 4'b1111);
    bus_read(5'h05, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL absent_out got=%h exp=0", d); end
    bus_write(5'h08, 32'hFFFF_FFFF, 4'b1111);
    bus_read(5'h08, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL in_ro got=%h exp=0", d); end
    bus_write(5'h10, 32'hFFFF_FFFF, 4'b0001);
    bus_read(5'h10, d);
    total++; if (d !== 32'h0000_00FF) begin bad++; $display("FAIL mask_be got=%h exp=000000ff", d); end
    bus_write(5'h10, 32'h0, 4'b1111);
  endtask

  task automatic test_rw_same();
    logic [31:0] d;
    @(negedge clk);
    avs_address = 5'h02; avs_read = 1'b1; avs_write = 1'b1;
    avs_writedata = 32'hCAFE_F00D; avs_byteenable = 4'b1111;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    total++; if (avs_readdata !== OUT_RST) begin bad++; $display("FAIL rw_pre got=%h exp=%h", avs_readdata, OUT_RST); end
    bus_read(5'h02, d);
    total++; if (d !== 32'hCAFE_F00D) begin bad++; $display("FAIL rw_post got=%h exp=cafef00d", d); end
  endtask

  task automatic test_priming();
    logic [31:0] d;
    do_reset(64'h3);
    repeat (30) @(negedge clk);
    bus_read(5'h08, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL prime_in got=%h exp=3", d); end
    bus_read(5'h0C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL prime_edge got=%h exp=0", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL prime_irq got=%b exp=0", irq); end
    bus_read(5'h00, d);
    total++; if (d !== OUT_RST) begin bad++; $display("FAIL prime_out got=%h exp=%h", d, OUT_RST); end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      in_export[31:0] = 32'h7;
      repeat (4) @(negedge clk);
      in_export[31:0] = 32'h3;
      @(negedge clk);
    end
    bus_read(5'h08, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL db_glitch got=%h exp=3", d); end
    in_export[31:0] = 32'h7;
    repeat (5) @(negedge clk);
    bus_read(5'h08, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL db_early got=%h exp=3", d); end
    repeat (10) @(negedge clk);
    bus_read(5'h08, d);
    total++; if (d !== 32'h7) begin bad++; $display("FAIL db_settled got=%h exp=7", d); end
    bus_read(5'h0C, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL db_edge got=%h exp=4", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL db_irq_masked got=%b exp=0", irq); end
    bus_write(5'h0C, 32'h4, 4'b1111);
    in_export[31:0] = 32'h3;
    repeat (20) @(negedge clk);
    bus_read(5'h0C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL db_fall_ignored got=%h exp=0", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int cyc;
    bus_write(5'h10, 32'h1, 4'b1111);
    in_export[31:0] = 32'h2;
    repeat (20) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", irq); end
    in_export[31:0] = 32'h3;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (irq === 1'b1) begin cyc = i; break; end
    end
    total++; if (cyc != 12) begin bad++; $display("FAIL irq_latency got=%0d exp=12", cyc); end
    bus_read(5'h14, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL irqstat got=%h exp=1", d); end
    @(negedge clk);
    avs_address = 5'h0C; avs_writedata = 32'h1; avs_byteenable = 4'b0000; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_hold got=%b exp=1", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_drop got=%b exp=0", irq); end
    bus_read(5'h0C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_edge got=%h exp=0", d); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    in_export[31:0] = 32'h2;
    repeat (20) @(negedge clk);
    in_export[31:0] = 32'h3;
    repeat (20) @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL sw_pre_irq got=%b exp=1", irq); end
    in_export[31:0] = 32'h2;
    repeat (20) @(negedge clk);
    in_export[31:0] = 32'h3;
    repeat (10) @(negedge clk);
    avs_address = 5'h0C; avs_writedata = 32'h1; avs_byteenable = 4'b1111; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL sw_irq_stay k=%0d got=%b exp=1", k, irq); end
    end
    bus_read(5'h0C, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL sw_edge got=%h exp=1", d); end
    bus_write(5'h10, 32'h0, 4'b1111);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq_hold got=%b exp=1", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_drop got=%b exp=0", irq); end
    bus_read(5'h14, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mask_irqstat got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_out_byteenable();
    test_rw_same();
    test_priming();
    test_debounce();
    test_irq();
    test_set_wins();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
